// File: rtl/filt_scan.sv
// Time-shared 0/1 hysteresis filter: one evaluator scans N channels round-robin
// per sample tick, holding per-channel run counts and levels, and reports flips.
module filt_scan #(
    parameter int unsigned N     = 8,
    parameter int unsigned IDX_W = 3,
    parameter int unsigned DIV   = 16,
    parameter int unsigned THR   = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [N-1:0]     i,
    output logic [N-1:0]     y,
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic [IDX_W-1:0] evt_idx,
    output logic             evt_lvl,
    output logic             busy,
    output logic             ovf,
    input  logic             ovf_clr
);

    localparam int unsigned TW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned CW  = (THR > 1) ? $clog2(THR + 1) : 1;
    localparam int unsigned CIW = CW + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        STALL = 2'd2
    } state_t;

    state_t           state;
    logic [TW-1:0]    tcnt;
    logic [N-1:0]     samp;
    logic [IDX_W-1:0] ptr;
    logic [CW-1:0]    cnt [N];

    logic             tick_c;
    logic             s_c;
    logic             lv_c;
    logic [CW-1:0]    c_c;
    logic [CIW-1:0]   c_inc_c;
    logic             flip_c;
    logic             slot_free_c;
    logic             last_c;

    // Sample tick divider; held at zero while disabled
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tcnt <= '0;
        end else if (!en) begin
            tcnt <= '0;
        end else if (tcnt == TW'(DIV - 1)) begin
            tcnt <= '0;
        end else begin
            tcnt <= tcnt + TW'(1);
        end
    end

    assign tick_c = en && (tcnt == TW'(DIV - 1));

    // Evaluator datapath for the channel under the scan pointer
    always_comb begin
        s_c         = samp[ptr];
        lv_c        = y[ptr];
        c_c         = cnt[ptr];
        c_inc_c     = CIW'(c_c) + CIW'(1);
        flip_c      = (s_c != lv_c) && (c_inc_c == CIW'(THR));
        slot_free_c = !evt_valid || evt_ready;
        last_c      = (ptr == IDX_W'(N - 1));
    end

    // Scan FSM, register bank and event slot
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            busy      <= 1'b0;
            samp      <= '0;
            ptr       <= '0;
            y         <= '0;
            evt_valid <= 1'b0;
            evt_idx   <= '0;
            evt_lvl   <= 1'b0;
            for (int unsigned k = 0; k < N; k++) begin
                cnt[k] <= '0;
            end
        end else begin
            if (evt_valid && evt_ready) begin
                evt_valid <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (tick_c) begin
                        samp  <= i;
                        ptr   <= '0;
                        state <= SCAN;
                        busy  <= 1'b1;
                    end
                end
                SCAN: begin
                    if (!flip_c || slot_free_c) begin
                        if (!flip_c) begin
                            cnt[ptr] <= (s_c == lv_c) ? '0 : c_inc_c[CW-1:0];
                        end else begin
                            y[ptr]    <= s_c;
                            cnt[ptr]  <= '0;
                            evt_valid <= 1'b1;
                            evt_idx   <= ptr;
                            evt_lvl   <= s_c;
                        end
                        if (last_c) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else begin
                            ptr <= ptr + IDX_W'(1);
                        end
                    end else begin
                        state <= STALL;
                    end
                end
                STALL: begin
                    if (slot_free_c) begin
                        state <= SCAN;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Sticky overflow: a tick that lands outside IDLE is dropped; set beats clear
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ovf <= 1'b0;
        end else if (tick_c && (state != IDLE)) begin
            ovf <= 1'b1;
        end else if (ovf_clr) begin
            ovf <= 1'b0;
        end
    end

endmodule

// File: tb/tb_filt_scan.sv
// Directed bench for filt_scan; cycle numbers count rising edges after reset release.
module tb_filt_scan;

    localparam int unsigned N     = 8;
    localparam int unsigned IDX_W = 3;
    localparam int unsigned DIV   = 16;
    localparam int unsigned THR   = 3;

    logic             clk;
    logic             rst;
    logic             en;
    logic [N-1:0]     i;
    logic [N-1:0]     y;
    logic             evt_valid;
    logic             evt_ready;
    logic [IDX_W-1:0] evt_idx;
    logic             evt_lvl;
    logic             busy;
    logic             ovf;
    logic             ovf_clr;

    int checks = 0;
    int errors = 0;
    int ec     = 0;
    int mcyc   = 0;
    int q_idx[$];
    int q_lvl[$];
    int q_cyc[$];

    filt_scan #(.N(N), .IDX_W(IDX_W), .DIV(DIV), .THR(THR)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .i         (i),
        .y         (y),
        .evt_valid (evt_valid),
        .evt_ready (evt_ready),
        .evt_idx   (evt_idx),
        .evt_lvl   (evt_lvl),
        .busy      (busy),
        .ovf       (ovf),
        .ovf_clr   (ovf_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Event log: every completed handshake with its edge number
    always @(posedge clk) begin
        mcyc = mcyc + 1;
        if (rst && evt_valid && evt_ready) begin
            q_idx.push_back(int'(evt_idx));
            q_lvl.push_back(int'(evt_lvl));
            q_cyc.push_back(mcyc);
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
            $error("check %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
        ec += n;
    endtask

    task automatic go(input int t);
        if (t > ec) cyc(t - ec);
    endtask

    initial begin
        bit pat[6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        int busy_cnt;
        int vld_cnt;
        int ovf_cnt;
        int y_bad;

        rst = 1'b1; en = 1'b1; i = '0; evt_ready = 1'b1; ovf_clr = 1'b0;
        #1 rst = 1'b0;
        #1;
        check("rst_y", y, 8'h00);
        check("rst_valid", evt_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_ovf", ovf, 1'b0);
        #1 rst = 1'b1;

        // Quiet inputs: one 8-cycle busy pulse per tick, nothing else
        go(15);
        check("t1_busy_pre", busy, 1'b0);
        go(16);
        check("t1_busy_rise", busy, 1'b1);
        busy_cnt = 0; vld_cnt = 0; ovf_cnt = 0; y_bad = 0;
        for (int k = 0; k < 160; k++) begin
            if (busy) busy_cnt++;
            if (evt_valid) vld_cnt++;
            if (ovf) ovf_cnt++;
            if (y != '0) y_bad++;
            cyc(1);
        end
        check("t1_busy_cycles", busy_cnt, 80);
        check("t1_no_events", vld_cnt, 0);
        check("t1_no_ovf", ovf_cnt, 0);
        check("t1_y_zero", y_bad, 0);

        // Channel 2 rises after three ticks, then falls after three more
        i = 8'h04;
        go(226);
        check("t2_y2_before", y, 8'h00);
        go(227);
        check("t2_y2_rise", y, 8'h04);
        check("t2_valid", evt_valid, 1'b1);
        check("t2_idx", evt_idx, 3'd2);
        check("t2_lvl", evt_lvl, 1'b1);
        go(228);
        check("t2_valid_drop", evt_valid, 1'b0);
        i = 8'h00;
        go(274);
        check("t2_y2_hold", y, 8'h04);
        go(275);
        check("t2_y2_fall", y, 8'h00);
        check("t2_fall_idx", evt_idx, 3'd2);
        check("t2_fall_lvl", evt_lvl, 1'b0);
        go(276);
        check("t2_evt_count", q_idx.size(), 2);
        check("t2_evt0", {q_idx[0], q_lvl[0]}, {32'd2, 32'd1});
        check("t2_evt1", {q_idx[1], q_lvl[1]}, {32'd2, 32'd0});

        // Channel 5: a single 0 restarts the run
        for (int k = 0; k < 6; k++) begin
            go(280 + 16 * k);
            i[5] = pat[k];
        end
        go(373);
        check("t3_y5_before", y, 8'h00);
        go(374);
        check("t3_y5_rise", y, 8'h20);
        check("t3_idx", evt_idx, 3'd5);
        go(376);
        check("t3_evt_count", q_idx.size(), 3);
        check("t3_evt", {q_idx[2], q_lvl[2]}, {32'd5, 32'd1});

        // All channels flip together with the consumer blocked
        i = 8'hDF;
        go(412);
        evt_ready = 1'b0;
        go(420);
        check("t4_stall_y", y, 8'h21);
        check("t4_stall_valid", evt_valid, 1'b1);
        check("t4_stall_idx", evt_idx, 3'd0);
        check("t4_stall_busy", busy, 1'b1);
        go(440);
        check("t4_ovf_set", ovf, 1'b1);
        evt_ready = 1'b1;
        go(450);
        check("t4_y_all", y, 8'hDF);
        check("t4_valid_idle", evt_valid, 1'b0);
        check("t4_busy_idle", busy, 1'b0);
        check("t4_evt_count", q_idx.size(), 11);
        for (int k = 0; k < 8; k++) begin
            check("t4_evt_idx", q_idx[3 + k], k);
            check("t4_evt_lvl", q_lvl[3 + k], (k == 5) ? 0 : 1);
            check("t4_evt_cyc", q_cyc[3 + k], (k == 0) ? 441 : 442 + k);
        end
        check("t4_ovf_still", ovf, 1'b1);
        ovf_clr = 1'b1;
        cyc(1);
        ovf_clr = 1'b0;
        check("t4_ovf_clr", ovf, 1'b0);

        // Asynchronous reset with an event pending mid-scan
        i = 8'hFF;
        evt_ready = 1'b0;
        go(503);
        check("t5_pend_valid", evt_valid, 1'b1);
        check("t5_pend_idx", evt_idx, 3'd5);
        check("t5_pend_busy", busy, 1'b1);
        #1 rst = 1'b0;
        #1;
        check("t5_async_y", y, 8'h00);
        check("t5_async_valid", evt_valid, 1'b0);
        check("t5_async_idx", evt_idx, 3'd0);
        check("t5_async_busy", busy, 1'b0);
        cyc(2);
        rst = 1'b1;
        evt_ready = 1'b1;
        go(553);
        check("t5_fresh_before", y, 8'h00);
        go(554);
        check("t5_fresh_ch0", y, 8'h01);
        go(561);
        check("t5_fresh_all", y, 8'hFF);
        go(562);
        check("t5_evt_count", q_idx.size(), 19);
        for (int k = 0; k < 8; k++) begin
            check("t5_evt_idx", q_idx[11 + k], k);
        end

        // Disable mid-scan: scan finishes, no ticks until re-enabled
        go(571);
        en = 1'b0;
        go(576);
        check("t6_busy_finish", busy, 1'b1);
        go(577);
        check("t6_busy_done", busy, 1'b0);
        busy_cnt = 0;
        for (int k = 0; k < 40; k++) begin
            if (busy) busy_cnt++;
            cyc(1);
        end
        check("t6_no_ticks", busy_cnt, 0);
        en = 1'b1;
        go(632);
        check("t6_reen_pre", busy, 1'b0);
        go(633);
        check("t6_reen_tick", busy, 1'b1);
        cyc(10);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
